imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Controls a writable instruction memory. Reassembles a big-endian byte stream from a debug loader into 32-bit words and writes them.
//  The CPU is held (stalled, fetch returns NOP) for the whole load and released when the load finishes or aborts.
//  Sits between the fetch stage, the loader interface and the instruction memory write port.
// PARAMETERS
//  IMEM_WORDS  256  depth in words (= `IMEM_SIZE/4)
//  WADDR_W     8    word-address width (= `IMEM_ADDR_WIDTH-2)
// PORTS
//  clk           in   1        system clock
//  rst           in   1        asynchronous, active-low reset
//  ld_start      in   1        pulse: begin load (sampled in IDLE only)
//  ld_len        in   WADDR_W+1  words to load, sampled with ld_start
//  ld_abort      in   1        cancel load in progress
//  ld_valid      in   1        loader byte valid
//  ld_byte       in   8        loader byte
//  ld_ready      out  1        controller can accept a byte
//  fetch_iaddr   in   32       CPU fetch byte address
//  fetch_idata   out  32       instruction to CPU (NOP while held)
//  imem_idata    in   32       read data from instruction memory
//  imem_iaddr    out  32       read address to instruction memory (= fetch_iaddr)
//  mem_we        out  1        word write strobe
//  mem_waddr     out  WADDR_W  word write address
//  mem_wdata     out  32       word write data
//  cpu_hold      out  1        stall PC / pipeline
//  load_done     out  1        1-cycle pulse: load completed OK
//  load_err      out  1        1-cycle pulse: load aborted/failed
//  words_loaded  out  WADDR_W+1  words written by last/current load
// BEHAVIOUR
//  Reset: ld_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, words_loaded=0; FSM=IDLE.
//  FSM states: IDLE, LOAD, WRITE, DONE (+CHK with option).
//  IDLE: ld_start & ld_len!=0 -> LOAD; latch len (values >IMEM_WORDS clamp to IMEM_WORDS); clear counters.
//  ld_len==0 is ignored (stay IDLE, no pulse).
//  ld_start outside IDLE is ignored.
//  LOAD: ld_ready=1; byte accepted on ld_valid&ld_ready; the first byte goes to [31:24], the fourth to [7:0]; 2-bit byte_cnt.
//  The 4th accepted byte -> WRITE.
//  WRITE (1 cycle): ld_ready=0, mem_we=1, mem_waddr=word_cnt, mem_wdata=assembled word; then word_cnt++, words_loaded++.
//  From WRITE: word_cnt==len -> DONE (or CHK), else -> LOAD.
//  DONE (1 cycle): load_done=1; -> IDLE. cpu_hold is 1 in every state except IDLE, so it drops the cycle after DONE.
//  Write latency: 4th byte handshake at cycle N -> mem_we at cycle N+1. No byte is accepted in the WRITE cycle.
//  fetch_idata = cpu_hold ? 32'h00000000 : imem_idata. imem_iaddr = fetch_iaddr, combinational.
//  ld_abort in any non-IDLE state wins over all other events: -> IDLE next cycle, load_err=1, partial word dropped.
//    Words already written stay in memory; words_loaded is kept.
//  Async reset mid-load: immediate return to reset values; memory contents are not touched.
//  word_cnt never wraps: the clamp guarantees mem_waddr <= IMEM_WORDS-1.
// CONFIGURATION
//  IMEM_LOAD_CHKSUM_EN defined: after the last WRITE -> CHK with ld_ready=1; expects one byte equal to the XOR of all payload bytes.
//    Match -> DONE. Mismatch -> load_err=1 and IDLE, with no load_done.
//  IMEM_LOAD_CHKSUM_EN undefined: no CHK state and no XOR register; load_err is raised only by ld_abort.
// STRUCTURE
//  Marco.v: IMEM_SIZE, IMEM_ADDR_WIDTH, FSM state encodings (LDC_IDLE..LDC_CHK), NOP word constant.
//  Sub-module imem_word_packer: byte shift register + byte_cnt + word_full flag, with a clear input.
//  The FSM, counters and fetch mux stay in imem_load_ctrl.
// TESTING
//  1. ld_len=1, bytes 3C,18,00,07 -> single mem_we, waddr=0, wdata=32'h3c180007; load_done; cpu_hold 0 next cycle.
//  2. ld_len=3 with ld_valid gaps -> 3 writes at addr 0,1,2; words_loaded=3; ld_ready=0 in each WRITE cycle.
//  3. ld_len=300 -> clamped: 256 writes, last waddr=255, load_done; no wrap.
//  4. ld_abort after 6 bytes of ld_len=2 -> one write (addr 0), load_err pulse, IDLE; fetch_idata follows imem_idata again.
//  5. Hold checks: fetch_idata=0 during load; ld_start while busy ignored; rst low mid-word -> all outputs at reset values.
//  6. CHKSUM_EN: ld_len=1, bytes 01 02 03 04 then chk 04 -> load_done; chk 05 -> load_err and no load_done.

Source files
------------

// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the instruction-memory loader.
// The optional checksum stage is enabled by defining IMEM_LOAD_CHKSUM_EN.
package imem_load_ctrl_pkg;

    localparam int IMEM_SIZE       = 1024;
    localparam int IMEM_ADDR_WIDTH = 10;
    localparam int DEF_IMEM_WORDS  = IMEM_SIZE / 4;
    localparam int DEF_WADDR_W     = IMEM_ADDR_WIDTH - 2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        LDC_IDLE  = 3'd0,
        LDC_LOAD  = 3'd1,
        LDC_WRITE = 3'd2,
        LDC_DONE  = 3'd3,
        LDC_CHK   = 3'd4
    } ldc_state_e;

    // Running XOR over the payload used by the optional checksum stage.
    function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_load_ctrl_packer.sv
// Big-endian byte-to-word packer: the first byte of a word ends up in [31:24].
// o_word_full flags that the byte being shifted in this cycle completes a word.
module imem_word_packer
    import imem_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [23:0] r_bytes;
    logic [1:0]  r_byte_cnt;

    // Shift register and byte counter; clear drops any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bytes    <= 24'h00_0000;
            r_byte_cnt <= 2'd0;
        end else if (i_clear) begin
            r_bytes    <= 24'h00_0000;
            r_byte_cnt <= 2'd0;
        end else if (i_shift) begin
            r_bytes    <= {r_bytes[15:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end else begin
            r_bytes    <= r_bytes;
            r_byte_cnt <= r_byte_cnt;
        end
    end

    assign o_word      = {r_bytes, i_byte};
    assign o_word_full = i_shift && (r_byte_cnt == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: stalls the CPU, packs loader bytes into words and writes them.
// Define IMEM_LOAD_CHKSUM_EN to require a trailing XOR checksum byte before load_done.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int WADDR_W    = DEF_WADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_start,
    input  logic [WADDR_W:0]   ld_len,
    input  logic               ld_abort,
    input  logic               ld_valid,
    input  logic [7:0]         ld_byte,
    output logic               ld_ready,
    input  logic [31:0]        fetch_iaddr,
    output logic [31:0]        fetch_idata,
    input  logic [31:0]        imem_idata,
    output logic [31:0]        imem_iaddr,
    output logic               mem_we,
    output logic [WADDR_W-1:0] mem_waddr,
    output logic [31:0]        mem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [WADDR_W:0]   words_loaded
);

    localparam logic [WADDR_W:0] LEN_MAX = (WADDR_W + 1)'(IMEM_WORDS);
    localparam logic [WADDR_W:0] CNT_ONE = (WADDR_W + 1)'(1);

    ldc_state_e         r_state, w_state_nxt;
    logic [WADDR_W:0]   r_len, w_len_nxt;
    logic [WADDR_W:0]   r_word_cnt, w_cnt_nxt;
    logic               r_ld_ready, r_mem_we, r_cpu_hold, r_load_done, r_load_err;
    logic [WADDR_W-1:0] r_mem_waddr, w_waddr_nxt;
    logic [31:0]        r_mem_wdata, w_wdata_nxt;
    logic               w_we_nxt, w_err_nxt, w_clear, w_shift, w_accept;
    logic [31:0]        w_word;
    logic               w_word_full;
`ifdef IMEM_LOAD_CHKSUM_EN
    logic [7:0]         r_xor, w_xor_nxt;
`endif

    imem_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_shift     (w_shift),
        .i_byte      (ld_byte),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    assign w_accept = ld_valid && r_ld_ready;

    // Next-state and next-output decode; abort outranks every other event outside IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_word_cnt;
        w_waddr_nxt = r_mem_waddr;
        w_wdata_nxt = r_mem_wdata;
        w_we_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
`ifdef IMEM_LOAD_CHKSUM_EN
        w_xor_nxt   = r_xor;
`endif
        case (r_state)
            LDC_IDLE: begin
                if (ld_start && (ld_len != '0)) begin
                    w_state_nxt = LDC_LOAD;
                    w_len_nxt   = (ld_len > LEN_MAX) ? LEN_MAX : ld_len;
                    w_cnt_nxt   = '0;
                    w_clear     = 1'b1;
`ifdef IMEM_LOAD_CHKSUM_EN
                    w_xor_nxt   = 8'h00;
`endif
                end else begin
                    w_state_nxt = LDC_IDLE;
                end
            end
            LDC_LOAD: begin
                if (ld_abort) begin
                    w_state_nxt = LDC_IDLE;
                    w_err_nxt   = 1'b1;
                    w_clear     = 1'b1;
                end else if (w_accept) begin
                    w_shift = 1'b1;
`ifdef IMEM_LOAD_CHKSUM_EN
                    w_xor_nxt = xor_acc(r_xor, ld_byte);
`endif
                    if (w_word_full) begin
                        w_state_nxt = LDC_WRITE;
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = r_word_cnt[WADDR_W-1:0];
                        w_wdata_nxt = w_word;
                    end else begin
                        w_state_nxt = LDC_LOAD;
                    end
                end else begin
                    w_state_nxt = LDC_LOAD;
                end
            end
            LDC_WRITE: begin
                // The write strobe is already on the port this cycle, so the word is counted even on abort.
                w_cnt_nxt = r_word_cnt + CNT_ONE;
                if (ld_abort) begin
                    w_state_nxt = LDC_IDLE;
                    w_err_nxt   = 1'b1;
                    w_clear     = 1'b1;
                end else if ((r_word_cnt + CNT_ONE) == r_len) begin
`ifdef IMEM_LOAD_CHKSUM_EN
                    w_state_nxt = LDC_CHK;
`else
                    w_state_nxt = LDC_DONE;
`endif
                end else begin
                    w_state_nxt = LDC_LOAD;
                end
            end
            LDC_DONE: begin
                w_state_nxt = LDC_IDLE;
                w_err_nxt   = ld_abort;
            end
`ifdef IMEM_LOAD_CHKSUM_EN
            LDC_CHK: begin
                if (ld_abort) begin
                    w_state_nxt = LDC_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_accept) begin
                    if (ld_byte == r_xor) begin
                        w_state_nxt = LDC_DONE;
                    end else begin
                        w_state_nxt = LDC_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = LDC_CHK;
                end
            end
`endif
            default: begin
                w_state_nxt = LDC_IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= LDC_IDLE;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_ld_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 32'h0000_0000;
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_word_cnt  <= w_cnt_nxt;
            r_ld_ready  <= (w_state_nxt == LDC_LOAD) || (w_state_nxt == LDC_CHK);
            r_mem_we    <= w_we_nxt;
            r_mem_waddr <= w_waddr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_cpu_hold  <= (w_state_nxt != LDC_IDLE);
            r_load_done <= (w_state_nxt == LDC_DONE);
            r_load_err  <= w_err_nxt;
        end
    end

`ifdef IMEM_LOAD_CHKSUM_EN
    // Payload checksum accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xor <= 8'h00;
        end else begin
            r_xor <= w_xor_nxt;
        end
    end
`endif

    assign ld_ready     = r_ld_ready;
    assign mem_we       = r_mem_we;
    assign mem_waddr    = r_mem_waddr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;
    assign words_loaded = r_word_cnt;
    assign imem_iaddr   = fetch_iaddr;
    assign fetch_idata  = r_cpu_hold ? NOP_WORD : imem_idata;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: a load model queues expected writes and end events,
// a negedge monitor pops and compares them. Define IMEM_LOAD_CHKSUM_EN to exercise the checksum stage.
module tb_imem_load_ctrl;

    localparam int WADDR_W = 8;
    localparam int WORDS   = 256;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               ld_start = 1'b0;
    logic [WADDR_W:0]   ld_len = '0;
    logic               ld_abort = 1'b0;
    logic               ld_valid = 1'b0;
    logic [7:0]         ld_byte = 8'h00;
    logic               ld_ready;
    logic [31:0]        fetch_iaddr = 32'h0;
    logic [31:0]        fetch_idata;
    logic [31:0]        imem_idata = 32'h0;
    logic [31:0]        imem_iaddr;
    logic               mem_we;
    logic [WADDR_W-1:0] mem_waddr;
    logic [31:0]        mem_wdata;
    logic               cpu_hold;
    logic               load_done;
    logic               load_err;
    logic [WADDR_W:0]   words_loaded;

    imem_load_ctrl dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len), .ld_abort(ld_abort),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
        .fetch_iaddr(fetch_iaddr), .fetch_idata(fetch_idata), .imem_idata(imem_idata),
        .imem_iaddr(imem_iaddr), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int ev_seen = 0;
    bit exp_busy = 1'b0;
    bit check_release = 1'b0;
    wr_t        exp_wr_q[$];
    logic [1:0] exp_ev_q[$];   // 2'b10 = load_done, 2'b01 = load_err
    logic [7:0] pl_q[$];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (!ok) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch-side traffic changes mid-cycle, independent of the load.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            fetch_iaddr = $urandom;
            imem_idata  = $urandom;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write or an end-of-load pulse.
    always @(negedge clk) begin
        if (rst) begin
            chk(imem_iaddr == fetch_iaddr, "imem_iaddr", 64'(imem_iaddr), 64'(fetch_iaddr));
            if (check_release) begin
                chk(cpu_hold == 1'b0, "hold_release", 64'(cpu_hold), 64'd0);
                chk(fetch_idata == imem_idata, "fetch_release", 64'(fetch_idata), 64'(imem_idata));
                check_release = 1'b0;
            end
            if (load_err) exp_busy = 1'b0;
            if (exp_busy) begin
                chk(cpu_hold == 1'b1, "hold_busy", 64'(cpu_hold), 64'd1);
                chk(fetch_idata == 32'h0, "fetch_nop", 64'(fetch_idata), 64'd0);
            end
            if (mem_we) begin
                chk(ld_ready == 1'b0, "ready_in_write", 64'(ld_ready), 64'd0);
                if (exp_wr_q.size() == 0) begin
                    chk(1'b0, "unexpected_write", 64'(mem_waddr), 64'd0);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk(mem_waddr == w.addr, "waddr", 64'(mem_waddr), 64'(w.addr));
                    chk(mem_wdata == w.data, "wdata", 64'(mem_wdata), 64'(w.data));
                end
            end
            if (load_done || load_err) begin
                ev_seen++;
                if (exp_ev_q.size() == 0) begin
                    chk(1'b0, "unexpected_event", 64'({load_done, load_err}), 64'd0);
                end else begin
                    logic [1:0] e;
                    e = exp_ev_q.pop_front();
                    chk({load_done, load_err} == e, "event", 64'({load_done, load_err}), 64'(e));
                end
                if (load_err) begin
                    chk(cpu_hold == 1'b0, "hold_on_err", 64'(cpu_hold), 64'd0);
                    chk(fetch_idata == imem_idata, "fetch_on_err", 64'(fetch_idata), 64'(imem_idata));
                end
                if (load_done) begin
                    exp_busy = 1'b0;
                    check_release = 1'b1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            if (!(gaps && ($urandom_range(0, 2) == 0)) && ld_ready) begin
                ld_valid = 1'b1;
                ld_byte  = b;
                @(posedge clk);
                #1;
                ld_valid = 1'b0;
                return;
            end
        end
        chk(1'b0, "byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_load(input int len);
        @(negedge clk);
        ld_start = 1'b1;
        ld_len   = (WADDR_W + 1)'(len);
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        exp_busy = (len != 0);
    endtask

    // Model: word i = bytes 4i..4i+3 big-endian at address i, for min(len, 256) words.
    task automatic run_load(input int len_req, input int abort_after, input bit gaps,
                            input bit chk_good, input bit busy_start);
        int eff, nsend, ev0, exp_wl;
        logic [7:0] bytes[$];
        logic [7:0] x;
        eff = (len_req > WORDS) ? WORDS : len_req;
        if (pl_q.size() == 0) begin
            for (int i = 0; i < 4 * eff; i++) pl_q.push_back(8'($urandom));
        end
        bytes = pl_q;
        pl_q.delete();
        nsend  = (abort_after >= 0) ? abort_after : 4 * eff;
        exp_wl = nsend / 4;
        for (int i = 0; i < nsend / 4; i++) begin
            wr_t w;
            w.addr = 8'(i);
            w.data = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
            exp_wr_q.push_back(w);
        end
        x = 8'h00;
        foreach (bytes[i]) x = x ^ bytes[i];
        if (abort_after >= 0) begin
            exp_ev_q.push_back(2'b01);
        end else begin
`ifdef IMEM_LOAD_CHKSUM_EN
            exp_ev_q.push_back(chk_good ? 2'b10 : 2'b01);
`else
            exp_ev_q.push_back(2'b10);
`endif
        end
        ev0 = ev_seen;
        start_load(len_req);
        for (int i = 0; i < nsend; i++) begin
            if (busy_start && i == 1) begin
                ld_start = 1'b1;
                ld_len   = (WADDR_W + 1)'(7);
            end
            send_byte(bytes[i], gaps);
            ld_start = 1'b0;
        end
        if (abort_after >= 0) begin
            for (int t = 0; t < 20 && !ld_ready; t++) @(negedge clk);
            @(negedge clk);
            ld_abort = 1'b1;
            @(posedge clk);
            #1;
            ld_abort = 1'b0;
        end else begin
`ifdef IMEM_LOAD_CHKSUM_EN
            send_byte(chk_good ? x : (x ^ 8'h01), gaps);
`endif
        end
        for (int t = 0; t < 50 && ev_seen == ev0; t++) @(negedge clk);
        chk(ev_seen != ev0, "event_timeout", 64'(ev_seen), 64'(ev0 + 1));
        @(negedge clk);
        chk(words_loaded == (WADDR_W + 1)'(exp_wl), "words_loaded", 64'(words_loaded), 64'(exp_wl));
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk({ld_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, words_loaded} == '0,
            "reset_values", 64'({mem_waddr, mem_wdata}), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, known bytes.
        pl_q = '{8'h3C, 8'h18, 8'h00, 8'h07};
        run_load(1, -1, 1'b0, 1'b1, 1'b0);
        // Three words with valid gaps.
        run_load(3, -1, 1'b1, 1'b1, 1'b0);
        // Over-long request clamps to the full memory.
        run_load(300, -1, 1'b0, 1'b1, 1'b0);
        // Abort after six bytes of a two-word load.
        run_load(2, 6, 1'b0, 1'b1, 1'b0);
        // Zero-length start is ignored.
        start_load(0);
        repeat (4) @(negedge clk);
        chk(cpu_hold == 1'b0, "len0_hold", 64'(cpu_hold), 64'd0);
        chk(ld_ready == 1'b0, "len0_ready", 64'(ld_ready), 64'd0);
        // Start while busy is ignored.
        run_load(2, -1, 1'b1, 1'b1, 1'b1);
`ifdef IMEM_LOAD_CHKSUM_EN
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, -1, 1'b0, 1'b1, 1'b0);
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, -1, 1'b0, 1'b0, 1'b0);
`endif
        // Randomized loads, some aborted part-way.
        for (int n = 0; n < 16; n++) begin
            int len, ab;
            len = $urandom_range(1, 9);
            ab  = ($urandom_range(0, 9) < 3) ? $urandom_range(0, 4 * len - 1) : -1;
            run_load(len, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a word.
        start_load(2);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_busy = 1'b0;
        #1;
        chk({ld_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, words_loaded} == '0,
            "midload_reset", 64'({ld_ready, cpu_hold, words_loaded}), 64'd0);
        chk(fetch_idata == imem_idata, "reset_fetch", 64'(fetch_idata), 64'(imem_idata));
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk(cpu_hold == 1'b0, "post_reset_idle", 64'(cpu_hold), 64'd0);

        chk(exp_wr_q.size() == 0, "writes_left", 64'(exp_wr_q.size()), 64'd0);
        chk(exp_ev_q.size() == 0, "events_left", 64'(exp_ev_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
